// File: rtl/breakout_ctrl.sv
// Breakout game sequencer: game-mode FSM, per-frame paddle movement,
// lives/level bookkeeping and ball-launch pulses. All outputs registered.
module breakout_ctrl #(
    parameter int SCREEN_W   = 640,
    parameter int PADDLE_W   = 80,
    parameter int STEP       = 4,
    parameter int LIVES_INIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       other_out,
    input  logic [3:0] level,
    input  logic       ball_lost,
    input  logic       bricks_cleared,
    output logic [9:0] paddle_x,
    output logic [1:0] game_state,
    output logic [1:0] lives,
    output logic [3:0] cur_level,
    output logic [2:0] ball_speed,
    output logic       ball_launch
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [9:0]  CENTER = 10'((SCREEN_W - PADDLE_W) / 2);
    localparam logic [9:0]  XMAX   = 10'(SCREEN_W - PADDLE_W);
    localparam logic [10:0] XMAX11 = 11'(SCREEN_W - PADDLE_W);
    localparam logic [9:0]  STEP10 = 10'(STEP);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [1:0]  LIVES0 = 2'(LIVES_INIT);

    state_t     state_q, state_d;
    logic [9:0] paddle_q, paddle_d;
    logic [1:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;
    logic [2:0] speed_q, speed_d;
    logic       launch_q, launch_d;
    logic       key_q;
    logic       start_evt;
    logic [10:0] x_ext;

    // key_q resets high so a key held through reset is not seen as a press
    assign start_evt = other_out & ~key_q;
    assign x_ext     = {1'b0, paddle_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            paddle_q <= CENTER;
            lives_q  <= LIVES0;
            level_q  <= 4'd1;
            speed_q  <= 3'd1;
            launch_q <= 1'b0;
            key_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            paddle_q <= paddle_d;
            lives_q  <= lives_d;
            level_q  <= level_d;
            speed_q  <= speed_d;
            launch_q <= launch_d;
            key_q    <= other_out;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_evt) state_d = ST_PLAY;
            ST_PLAY: begin
                if (ball_lost) begin
                    if (lives_q == 2'd1) state_d = ST_OVER;
                end else if (!bricks_cleared && start_evt) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: if (start_evt) state_d = ST_PLAY;
            ST_OVER:  if (start_evt) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        paddle_d = paddle_q;
        lives_d  = lives_q;
        level_d  = level_q;
        launch_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                paddle_d = CENTER;
                lives_d  = LIVES0;
                if (start_evt) begin
                    level_d  = (level == 4'd0) ? 4'd1 : level;
                    launch_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // Priority: ball_lost > bricks_cleared > start_evt > paddle move
                if (ball_lost) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q != 2'd1) begin
                        paddle_d = CENTER;
                        launch_d = 1'b1;
                    end
                end else if (bricks_cleared) begin
                    level_d  = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
                    paddle_d = CENTER;
                    launch_d = 1'b1;
                end else if (!start_evt && frame_tick) begin
                    if (move_left && !move_right) begin
                        paddle_d = (x_ext < STEP11) ? 10'd0 : paddle_q - STEP10;
                    end else if (move_right && !move_left) begin
                        paddle_d = (x_ext + STEP11 > XMAX11) ? XMAX : paddle_q + STEP10;
                    end
                end
            end
            ST_OVER: begin
                // Leaving OVER restores the idle display values immediately
                if (start_evt) begin
                    paddle_d = CENTER;
                    lives_d  = LIVES0;
                end
            end
            default: ;
        endcase
        speed_d = (level_d > 4'd7) ? 3'd7 : level_d[2:0];
    end

    assign paddle_x    = paddle_q;
    assign game_state  = state_q;
    assign lives       = lives_q;
    assign cur_level   = level_q;
    assign ball_speed  = speed_q;
    assign ball_launch = launch_q;

endmodule

// File: tb/tb_breakout_ctrl.sv
// Directed bench for breakout_ctrl: a behavioural game model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_breakout_ctrl;

  localparam int M_CENTER = (640 - 80) / 2;
  localparam int M_XMAX   = 640 - 80;
  localparam int M_STEP   = 4;
  localparam int M_LIVES  = 3;

  logic       clk = 1'b0;
  logic       rst, frame_tick, move_left, move_right, other_out;
  logic [3:0] level;
  logic       ball_lost, bricks_cleared;
  logic [9:0] paddle_x;
  logic [1:0] game_state, lives;
  logic [3:0] cur_level;
  logic [2:0] ball_speed;
  logic       ball_launch;

  int checks = 0;
  int errors = 0;

  // model state: 0 idle, 1 play, 2 pause, 3 over
  int  m_state, m_x, m_lives, m_level;
  bit  m_launch, m_prev, m_valid = 0;

  breakout_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .move_left(move_left),
    .move_right(move_right), .other_out(other_out), .level(level),
    .ball_lost(ball_lost), .bricks_cleared(bricks_cleared),
    .paddle_x(paddle_x), .game_state(game_state), .lives(lives),
    .cur_level(cur_level), .ball_speed(ball_speed), .ball_launch(ball_launch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the game rules applied to the inputs sampled at the edge
  task automatic model_step(input bit r, input bit ft, input bit ml, input bit mr,
                            input bit oo, input int lv, input bit bl, input bit bc);
    bit se;
    if (r) begin
      m_state = 0; m_x = M_CENTER; m_lives = M_LIVES; m_level = 1;
      m_launch = 0; m_prev = 1; m_valid = 1;
      return;
    end
    se = oo && !m_prev;
    m_prev = oo;
    m_launch = 0;
    case (m_state)
      0: begin
        m_x = M_CENTER; m_lives = M_LIVES;
        if (se) begin
          m_state = 1; m_level = (lv == 0) ? 1 : lv; m_launch = 1;
        end
      end
      1: begin
        if (bl) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) m_state = 3;
          else begin m_x = M_CENTER; m_launch = 1; end
        end else if (bc) begin
          m_level = (m_level + 1 > 15) ? 15 : m_level + 1;
          m_x = M_CENTER; m_launch = 1;
        end else if (se) begin
          m_state = 2;
        end else if (ft) begin
          m_x = m_x + M_STEP * (int'(mr) - int'(ml));
          if (m_x < 0) m_x = 0;
          if (m_x > M_XMAX) m_x = M_XMAX;
        end
      end
      2: if (se) m_state = 1;
      default: if (se) begin m_state = 0; m_x = M_CENTER; m_lives = M_LIVES; end
    endcase
  endtask

  // compare process: model advances on each edge, DUT checked 1 time unit later
  initial begin
    forever begin
      @(posedge clk);
      model_step(rst, frame_tick, move_left, move_right, other_out, int'(level),
                 ball_lost, bricks_cleared);
      #1;
      if (m_valid) begin
        chk("m_state", int'(game_state), m_state);
        chk("m_paddle", int'(paddle_x), m_x);
        chk("m_lives", int'(lives), m_lives);
        chk("m_level", int'(cur_level), m_level);
        chk("m_speed", int'(ball_speed), (m_level > 7) ? 7 : m_level);
        chk("m_launch", int'(ball_launch), int'(m_launch));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic press();
    other_out = 1'b1; @(negedge clk); other_out = 1'b0;
  endtask

  task automatic lose();
    ball_lost = 1'b1; @(negedge clk); ball_lost = 1'b0;
  endtask

  task automatic clear();
    bricks_cleared = 1'b1; @(negedge clk); bricks_cleared = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; move_left = 1'b0; move_right = 1'b0;
    other_out = 1'b1; level = 4'd0; ball_lost = 1'b0; bricks_cleared = 1'b0;

    // reset with the start key held through it
    idle(2);
    chk("rst_state", int'(game_state), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_level", int'(cur_level), 1);
    chk("rst_speed", int'(ball_speed), 1);
    chk("rst_launch", int'(ball_launch), 0);
    rst = 1'b0;
    idle(10);
    chk("held_state", int'(game_state), 0);
    chk("held_paddle", int'(paddle_x), 280);
    other_out = 1'b0;
    idle(1);
    press();
    chk("start_state", int'(game_state), 1);
    chk("start_level0", int'(cur_level), 1);
    chk("start_launch", int'(ball_launch), 1);
    idle(1);
    chk("launch_once", int'(ball_launch), 0);

    // left clamp
    move_left = 1'b1;
    for (int k = 1; k <= 71; k++) begin
      frame();
      if (k == 1)  chk("left_tick1", int'(paddle_x), 276);
      if (k == 70) chk("left_tick70", int'(paddle_x), 0);
      if (k == 71) chk("left_tick71", int'(paddle_x), 0);
      idle(1);
    end
    move_right = 1'b1;
    for (int k = 0; k < 5; k++) begin frame(); idle(1); end
    chk("both_keys", int'(paddle_x), 0);

    // right clamp
    move_left = 1'b0;
    for (int k = 0; k < 200; k++) begin frame(); idle(1); end
    chk("right_clamp", int'(paddle_x), 560);
    move_right = 1'b0;

    // lives and game over
    lose();
    chk("lost1_lives", int'(lives), 2);
    chk("lost1_paddle", int'(paddle_x), 280);
    chk("lost1_launch", int'(ball_launch), 1);
    idle(1);
    lose();
    chk("lost2_lives", int'(lives), 1);
    chk("lost2_launch", int'(ball_launch), 1);
    idle(1);
    lose();
    chk("lost3_lives", int'(lives), 0);
    chk("lost3_state", int'(game_state), 3);
    chk("lost3_launch", int'(ball_launch), 0);
    idle(1);
    lose();
    chk("over_frozen", int'(lives), 0);
    idle(1);
    press();
    chk("over_to_idle", int'(game_state), 0);
    idle(1);
    level = 4'd15;
    press();
    chk("newgame_state", int'(game_state), 1);
    chk("newgame_lives", int'(lives), 3);
    chk("newgame_level", int'(cur_level), 15);
    idle(1);

    // same-cycle events at level 15, lives 2
    lose();
    idle(1);
    ball_lost = 1'b1; bricks_cleared = 1'b1; other_out = 1'b1;
    @(negedge clk);
    ball_lost = 1'b0; bricks_cleared = 1'b0; other_out = 1'b0;
    chk("same_lives", int'(lives), 1);
    chk("same_level", int'(cur_level), 15);
    chk("same_state", int'(game_state), 1);
    chk("same_launch", int'(ball_launch), 1);
    idle(1);
    chk("same_launch_off", int'(ball_launch), 0);
    clear();
    chk("sat_level", int'(cur_level), 15);
    chk("sat_speed", int'(ball_speed), 7);
    idle(1);

    // pause
    press();
    chk("pause_state", int'(game_state), 2);
    idle(1);
    move_right = 1'b1;
    frame();
    move_right = 1'b0;
    idle(1);
    lose();
    idle(1);
    clear();
    idle(1);
    chk("pause_paddle", int'(paddle_x), 280);
    chk("pause_lives", int'(lives), 1);
    chk("pause_state2", int'(game_state), 2);
    press();
    chk("resume_state", int'(game_state), 1);
    chk("resume_launch", int'(ball_launch), 0);
    idle(1);
    move_right = 1'b1;
    frame();
    move_right = 1'b0;
    chk("resume_move", int'(paddle_x), 284);

    // reset mid-play overrides a coincident event
    rst = 1'b1; ball_lost = 1'b1;
    @(negedge clk);
    rst = 1'b0; ball_lost = 1'b0;
    chk("midrst_state", int'(game_state), 0);
    chk("midrst_paddle", int'(paddle_x), 280);
    chk("midrst_lives", int'(lives), 3);
    chk("midrst_level", int'(cur_level), 1);
    chk("midrst_launch", int'(ball_launch), 0);

    // level increment and speed tracking
    level = 4'd6;
    idle(1);
    press();
    chk("lvl6_speed", int'(ball_speed), 6);
    idle(1);
    clear();
    chk("lvl7_level", int'(cur_level), 7);
    idle(1);
    clear();
    chk("lvl8_level", int'(cur_level), 8);
    chk("lvl8_speed", int'(ball_speed), 7);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
